servo_pwm_driver: RTL and testbench

//   Hobby-servo PWM generator for the gimbal/servo control path.

---
 rtl/servo_pwm_driver.sv | 61 ++++++
 tb/tb_servo_pwm_driver.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator: an 8-bit angle maps linearly onto the pulse width inside a fixed frame.
// A new width is latched only at the frame boundary, so a pulse is never cut short or stretched.
module servo_pwm_driver #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned PWM_FREQ     = 50,
  parameter int unsigned MIN_PULSE_US = 500,
  parameter int unsigned MAX_PULSE_US = 2500,
  parameter int unsigned MAX_ANGLE    = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] angle,
  output logic       servo_pwm
);

  localparam int unsigned TPU    = CLK_FREQ / 1_000_000;
  localparam int unsigned MINW   = MIN_PULSE_US * TPU;
  localparam int unsigned SPAN   = (MAX_PULSE_US - MIN_PULSE_US) * TPU;
  localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int unsigned CntW   = $clog2(PERIOD);
  localparam int unsigned MulW   = 8 + $clog2(SPAN + 1);

  logic [7:0]      ang_q, ang_d;
  logic [CntW-1:0] pend_w_q, pend_w_d;
  logic [CntW-1:0] act_w_q, act_w_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pwm_q, pwm_d;
  logic [MulW-1:0] prod, quot;
  logic            wrap;

  always_comb begin
    ang_d    = (angle > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : angle;
    // ang_q is already clamped, so the product fits MulW bits.
    prod     = MulW'(ang_q) * MulW'(SPAN);
    quot     = prod / MulW'(MAX_ANGLE);
    pend_w_d = CntW'(MINW) + CntW'(quot);
    wrap     = (cnt_q == CntW'(PERIOD - 1));
    cnt_d    = wrap ? '0 : cnt_q + CntW'(1);
    act_w_d  = wrap ? pend_w_q : act_w_q;
    pwm_d    = (cnt_q < act_w_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ang_q    <= '0;
      pend_w_q <= CntW'(MINW);
      act_w_q  <= CntW'(MINW);
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      ang_q    <= ang_d;
      pend_w_q <= pend_w_d;
      act_w_q  <= act_w_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign servo_pwm = pwm_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboard bench for servo_pwm_driver, scaled to a 500-clock frame with 50..250-clock pulses.
module tb_servo_pwm_driver;

  localparam int unsigned Period = 500;
  localparam int unsigned NRows  = 17;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] angle;
  logic       servo_pwm;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  servo_pwm_driver #(
    .CLK_FREQ    (1_000_000),
    .PWM_FREQ    (2000),
    .MIN_PULSE_US(50),
    .MAX_PULSE_US(250),
    .MAX_ANGLE   (180)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .angle    (angle),
    .servo_pwm(servo_pwm)
  );

  always #5 clk = ~clk;

  // Row k: expected width of frame k, angle driven during frame k, clocks after the rise to drive it.
  // ticks(a) = 50 + floor(min(a,180)*200/180).
  int          row_w   [NRows] = '{50, 100, 100, 150, 150, 200, 200, 250, 250, 250, 150, 50, 51,
                                   248, 161, 161, 100};
  logic [7:0]  row_ang [NRows] = '{8'd45, 8'd45, 8'd90, 8'd90, 8'd135, 8'd135, 8'd180, 8'd200,
                                   8'd255, 8'd90, 8'd0, 8'd1, 8'd179, 8'd100, 8'd45, 8'd45, 8'd90};
  int          row_at  [NRows] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10,
                                   Period - 4, Period - 3, 10, 10};

  // Monitor: measures every pulse width and rise-to-rise period.
  initial begin : monitor
    int   cyc = 0;
    int   last_rise = 0;
    bit   have_rise = 1'b0;
    bit   abort = 1'b1;
    logic prev = 1'b0;
    int   w;
    int   e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        abort     = 1'b1;
        have_rise = 1'b0;
      end
      if (servo_pwm === 1'b1 && prev === 1'b0) begin
        if (have_rise) begin
          n_checks++;
          if (cyc - last_rise != int'(Period)) begin
            n_fail++;
            $display("FAIL period: got %0d clocks, expected %0d", cyc - last_rise, Period);
          end
        end
        last_rise = cyc;
        have_rise = 1'b1;
        abort     = 1'b0;
      end
      if (servo_pwm === 1'b0 && prev === 1'b1 && !abort) begin
        w = cyc - last_rise;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_width: got unexpected pulse of %0d clocks, expected none", w);
        end else begin
          e = exp_q.pop_front();
          if (w != e) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d clocks, expected %0d", w, e);
          end
        end
      end
      prev = servo_pwm;
    end
  end

  task automatic wait_rise(output bit ok);
    logic p;
    p  = servo_pwm;
    ok = 1'b0;
    for (int i = 0; i < 2 * int'(Period); i++) begin
      @(posedge clk);
      #1;
      if (servo_pwm === 1'b1 && p === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = servo_pwm;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rise_timeout: got no rising edge in %0d clocks, expected one", 2 * Period);
    end
  endtask

  task automatic frame(input int exp_w, input logic [7:0] next_ang, input int set_at);
    bit ok;
    wait_rise(ok);
    if (ok) exp_q.push_back(exp_w);
    repeat (set_at) @(posedge clk);
    #1;
    angle = next_ang;
  endtask

  initial begin : stimulus
    bit ok;
    rst_n = 1'b0;
    angle = 8'd0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (servo_pwm !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_low: got %b, expected 0", servo_pwm);
      end
    end
    rst_n = 1'b1;

    for (int k = 0; k < int'(NRows); k++) frame(row_w[k], row_ang[k], row_at[k]);

    // Reset for one clock in the middle of a 150-clock pulse.
    wait_rise(ok);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (servo_pwm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midpulse: got %b, expected 0", servo_pwm);
    end
    rst_n = 1'b1;
    frame(50, 8'd90, 10);
    frame(150, 8'd90, 10);

    for (int i = 0; i < 2 * int'(Period) && exp_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pulses outstanding, expected 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
